// File: rtl/mc_controller.sv
// Multicycle control unit for the ARM-subset datapath: a Moore sequencer that
// drives every datapath enable and select, and owns the NZCV flag register.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXECR  = 4'd2,
        EXECI  = 4'd3,
        ALUWB  = 4'd4,
        MEMADR = 4'd5,
        MEMRD  = 4'd6,
        MEMWB  = 4'd7,
        MEMWR  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state, next_state;
    logic [3:0] flags;

    logic [1:0] op;
    logic       imm;
    logic [3:0] cmd;
    logic       s_bit;
    logic [3:0] rd;
    logic [3:0] cond;
    logic       rd_pc;

    assign op    = Instr[27:26];
    assign imm   = Instr[25];
    assign cmd   = Instr[24:21];
    assign s_bit = Instr[20];
    assign rd    = Instr[15:12];
    assign cond  = Instr[31:28];
    assign rd_pc = (rd == 4'd15);

    logic unused_instr;
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_check = z;
            4'b0001: cond_check = !z;
            4'b0010: cond_check = cf;
            4'b0011: cond_check = !cf;
            4'b0100: cond_check = n;
            4'b0101: cond_check = !n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = !v;
            4'b1000: cond_check = cf & !z;
            4'b1001: cond_check = !(cf & !z);
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = !z & (n == v);
            4'b1101: cond_check = z | (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    logic cond_ex;
    assign cond_ex = cond_check(cond, flags);

    // Data-processing command decode; unlisted commands behave as a NOP.
    logic [1:0] dp_ctl;
    logic       no_write;
    logic       nop;
    logic       cv_update;

    always_comb begin
        dp_ctl    = 2'b00;
        no_write  = 1'b0;
        nop       = 1'b0;
        cv_update = 1'b0;
        case (cmd)
            4'b0100: begin dp_ctl = 2'b00; cv_update = 1'b1; end
            4'b0010: begin dp_ctl = 2'b01; cv_update = 1'b1; end
            4'b0000: dp_ctl = 2'b10;
            4'b1100: dp_ctl = 2'b11;
            4'b1010: begin dp_ctl = 2'b01; no_write = 1'b1; cv_update = 1'b1; end
            default: nop = 1'b1;
        endcase
    end

    logic in_exec;
    logic flag_en;
    assign in_exec = (state == EXECR) || (state == EXECI);
    assign flag_en = in_exec & s_bit & cond_ex & !nop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            flags <= 4'b0000;
        end else begin
            state <= next_state;
            if (flag_en)
                flags <= {ALUFlags[3:2], cv_update ? ALUFlags[1:0] : flags[1:0]};
        end
    end

    logic dp_commit;
    assign dp_commit = cond_ex & !no_write & !nop;

    always_comb begin
        next_state = FETCH;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ResultSrc  = 2'd0;
        ALUControl = 2'b00;
        RegSrc     = {(op == 2'b01) & !s_bit, (op == 2'b10)};
        ImmSrc     = op;
        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'd2;
                PCWrite    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                case (op)
                    2'b00:   next_state = imm ? EXECI : EXECR;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            EXECR: begin
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd0;
                ALUControl = dp_ctl;
                next_state = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd1;
                ALUControl = dp_ctl;
                next_state = ALUWB;
            end
            ALUWB: begin
                ResultSrc  = 2'd1;
                RegWrite   = dp_commit & !rd_pc;
                PCWrite    = dp_commit & rd_pc;
                next_state = FETCH;
            end
            MEMADR: begin
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd1;
                next_state = s_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'd2;
                RegWrite   = cond_ex & !rd_pc;
                PCWrite    = cond_ex & rd_pc;
                next_state = FETCH;
            end
            MEMWR: begin
                AdrSrc     = 1'b1;
                MemWrite   = cond_ex;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd1;
                PCWrite    = cond_ex;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instructions plus random ones, each cycle's
// control vector compared against a per-instruction reference sequence.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    int n_checks = 0;
    int n_fails  = 0;
    logic [3:0] mflags;

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    logic [16:0] outs;
    assign outs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    // Build the expected control vector; RegSrc/ImmSrc depend only on the instruction.
    function automatic logic [16:0] vec(input logic [31:0] ins, input logic pcw,
                                        input logic memw, input logic regw, input logic irw,
                                        input logic adr, input logic [1:0] asa,
                                        input logic [1:0] asb, input logic [1:0] rs,
                                        input logic [1:0] ctl);
        logic [1:0] o;
        logic [1:0] rsrc;
        o = ins[27:26];
        rsrc = {(o == 2'b01) && !ins[20], (o == 2'b10)};
        return {pcw, memw, regw, irw, adr, rsrc, asa, asb, rs, o, ctl};
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            0: return z;               1: return !z;
            2: return cc;              3: return !cc;
            4: return n;               5: return !n;
            6: return v;               7: return !v;
            8: return cc && !z;        9: return !cc || z;
            10: return n == v;         11: return n != v;
            12: return !z && n == v;   13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // {ctl[1:0], no_write, nop, cv_update}
    function automatic logic [4:0] dp_info(input logic [3:0] c);
        case (c)
            4'b0100: return 5'b00_0_0_1;
            4'b0010: return 5'b01_0_0_1;
            4'b0000: return 5'b10_0_0_0;
            4'b1100: return 5'b11_0_0_0;
            4'b1010: return 5'b01_1_0_1;
            default: return 5'b00_0_1_0;
        endcase
    endfunction

    task automatic check(input logic [16:0] obs, input logic [16:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic step(input logic [16:0] exp, input string tag, input logic [3:0] af);
        ALUFlags = af;
        @(negedge clk);
        check(outs, exp, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        n_checks++;
        assert (dut.flags === mflags) else begin
            n_fails++;
            $error("FAIL %s flags observed=%b expected=%b", tag, dut.flags, mflags);
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af_exec);
        logic [1:0] op;
        logic [3:0] cd, rd;
        logic [4:0] info;
        logic       ce, wr, ld;
        Instr = ins;
        op = ins[27:26]; cd = ins[31:28]; rd = ins[15:12]; ld = ins[20];
        info = dp_info(ins[24:21]);
        step(vec(ins, 1, 0, 0, 1, 0, 0, 2, 0, 0), "fetch", 4'($urandom));
        step(vec(ins, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode", 4'($urandom));
        ce = cond_ok(cd, mflags);
        case (op)
            2'b00: begin
                step(vec(ins, 0, 0, 0, 0, 0, 1, {1'b0, ins[25]}, 0, info[4:3]), "exec", af_exec);
                if (ins[20] && ce && !info[1])
                    mflags = {af_exec[3:2], info[0] ? af_exec[1:0] : mflags[1:0]};
                wr = cond_ok(cd, mflags) && !info[2] && !info[1];
                step(vec(ins, wr && rd == 15, 0, wr && rd != 15, 0, 0, 0, 0, 1, 0),
                     "aluwb", 4'($urandom));
            end
            2'b01: begin
                step(vec(ins, 0, 0, 0, 0, 0, 1, 1, 0, 0), "memadr", 4'($urandom));
                if (ld) begin
                    step(vec(ins, 0, 0, 0, 0, 1, 0, 0, 0, 0), "memrd", 4'($urandom));
                    step(vec(ins, ce && rd == 15, 0, ce && rd != 15, 0, 0, 0, 0, 2, 0),
                         "memwb", 4'($urandom));
                end else begin
                    step(vec(ins, 0, ce, 0, 0, 1, 0, 0, 0, 0), "memwr", 4'($urandom));
                end
            end
            2'b10: step(vec(ins, ce, 0, 0, 0, 0, 1, 1, 0, 0), "branch", 4'($urandom));
            default: ;
        endcase
        check_flags("flags_after");
    endtask

    initial begin
        logic [31:0] ins;
        reset = 1'b1;
        Instr = 32'h0;
        ALUFlags = 4'h0;
        mflags = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(outs, vec(32'h0, 1, 0, 0, 1, 0, 0, 2, 0, 0), "reset_outputs");
        check_flags("reset_flags");
        reset = 1'b0;

        run_instr(32'hE2921005, 4'b0100);   // ADDS R1,R2,#5
        run_instr(32'hE3510005, 4'b0100);   // CMP R1,#5 -> Z
        run_instr(32'h1A000002, 4'b0000);   // BNE, not taken
        run_instr(32'hE5903004, 4'b0000);   // LDR R3,[R0,#4]
        run_instr(32'hE590F000, 4'b0000);   // LDR PC,[R0]
        run_instr(32'hE5803008, 4'b0000);   // STR R3,[R0,#8]
        run_instr(32'hF2921005, 4'b1111);   // never-condition ADDS
        run_instr(32'hF2821005, 4'b1111);   // never-condition ADD
        run_instr(32'hEC000000, 4'b0000);   // undefined op
        run_instr(32'h0A000001, 4'b0000);   // BEQ taken (Z still set)

        // Reset asserted in the middle of a load's MEMRD cycle.
        Instr = 32'hE5903004;
        step(vec(Instr, 1, 0, 0, 1, 0, 0, 2, 0, 0), "rst_fetch", 4'h0);
        step(vec(Instr, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_decode", 4'h0);
        step(vec(Instr, 0, 0, 0, 0, 0, 1, 1, 0, 0), "rst_memadr", 4'h0);
        #2;
        check(outs, vec(Instr, 0, 0, 0, 0, 1, 0, 0, 0, 0), "rst_memrd");
        reset = 1'b1;
        #1;
        mflags = 4'b0000;
        check(outs, vec(Instr, 1, 0, 0, 1, 0, 0, 2, 0, 0), "rst_async_fetch");
        check_flags("rst_async_flags");
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(32'h0A000001, 4'b0000);   // BEQ not taken after flag clear

        for (int i = 0; i < 250; i++) begin
            ins = $urandom;
            if ($urandom_range(1)) ins[24:21] = 4'($urandom_range(4)) == 0 ? 4'b0100 :
                                                  ($urandom_range(1) ? 4'b0010 : 4'b1010);
            if ($urandom_range(2) == 0) ins[31:28] = 4'b1110;
            if ($urandom_range(3) == 0) ins[15:12] = 4'd15;
            if ($urandom_range(7) == 0) ins[31:28] = 4'b1111;
            run_instr(ins, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control unit for the ARM-subset processor. It decodes the latched instruction and the ALU flags from the datapath, sequences each instruction through a Moore FSM, and drives every datapath enable and mux select plus the memory write strobe. It holds the NZCV flag register and evaluates the condition code, gating architectural writes. It sits directly upstream of the datapath control inputs and consumes its Instr/ALUFlags outputs.

Parameters:
None. All widths are fixed by the datapath interface.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH and clears flags
Instr  in  32  latched instruction from the datapath instruction register
ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
PCWrite  out  1  PC register enable
MemWrite  out  1  data memory write strobe
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
RegSrc  out  2  [0]: RA1=R15; [1]: RA2=Rd
ALUSrcA  out  2  0=PC, 1=A, 2=zero
ALUSrcB  out  2  0=WriteData, 1=ExtImm, 2=const 4
ResultSrc  out  2  0=ALUResult, 1=ALUOut, 2=ReadData
ImmSrc  out  2  00=8-bit DP, 01=12-bit mem, 10=24-bit branch
ALUControl  out  2  00=add, 01=sub, 10=and, 11=orr

Behaviour:
- Reset is asynchronous and active-high. On assertion, state=FETCH and Flags=4'b0000 immediately, including mid-instruction; no partial write completes.
- Field decode: Op=Instr[27:26], I=Instr[25], cmd=Instr[24:21], S/L=Instr[20], Rd=Instr[15:12], cond=Instr[31:28].
- Combinational outputs: RegSrc[0]=(Op==10); RegSrc[1]=(Op==01 & !L); ImmSrc=Op.
- Command decode, DP only: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11, 1010 CMP->01 with NoWrite. Any other cmd is a NOP: ALUControl 00, no register write, no flag write.
- CondEx is evaluated from the stored Flags, not ALUFlags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1, 1111 = 0 (never)
- Default every enable to 0 and every select to 0 unless the state says otherwise.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=0, ALUSrcB=2, ALUControl=00, ResultSrc=0, PCWrite=1 (PC<=PC+4). Next state is DECODE.
- DECODE: register reads latch into A and WriteData; no enables asserted. Next state:
  - Op=00 & I=0 -> EXECR
  - Op=00 & I=1 -> EXECI
  - Op=01 -> MEMADR
  - Op=10 -> BRANCH
  - Op=11 -> FETCH (undefined, no side effects)
- EXECR: ALUSrcA=1, ALUSrcB=0. EXECI: ALUSrcA=1, ALUSrcB=1. Both then go to ALUWB.
- Flag update happens on the EXECR/EXECI clock edge when S & CondEx & !NOP:
  - NZ are always loaded from ALUFlags.
  - CV are loaded only for ADD/SUB/CMP.
- ALUWB: ResultSrc=1.
  - RegWrite=CondEx & !NoWrite & !NOP & Rd!=15.
  - PCWrite=CondEx & !NoWrite & !NOP & Rd==15.
  - Next state is FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=1, ALUControl=00. Next state is MEMRD if L, else MEMWR.
- MEMRD: AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=2. RegWrite=CondEx & Rd!=15; PCWrite=CondEx & Rd==15. Next state is FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=1, ALUControl=00, ResultSrc=0, PCWrite=CondEx. Next state is FETCH.
- Latency in cycles, FETCH inclusive: DP=4, LDR=5, STR=4, B=3, undefined=2. A failed condition traverses the same states with all writes suppressed.
- Unreachable state encodings return to FETCH on the next edge with no enables asserted.

Test Plan:
- Assert reset mid-MEMRD -> same cycle: state=FETCH, IRWrite=1, PCWrite=1, MemWrite=0; Flags=0000.
- ADDS R1,R2,#5 (E2921005), ALUFlags=0100 in EXECI -> states FETCH,DECODE,EXECI,ALUWB; ALUControl=00; Flags become 0100; RegWrite=1 only in ALUWB.
- CMP R1,#5 (E3510005) setting Z, then BNE (1A000002) -> CMP gives RegWrite=0 throughout; BRANCH has PCWrite=0, i.e. not taken.
- LDR R3,[R0,#4] (E5903004) -> 5 states; AdrSrc=1 in MEMRD; ResultSrc=2 and RegWrite=1 in MEMWB.
- LDR PC,[R0] (E590F000) -> MEMWB asserts PCWrite=1 with RegWrite=0.
- STR R3,[R0,#8] (E5803008) -> RegSrc=10; MemWrite=1 for exactly one cycle in MEMWR.
- Condition 1111 DP (F2821005) -> no RegWrite, no flag change.
- Op=11 (EC000000) -> DECODE goes to FETCH.
